// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared types and saturation helper for the softmax forward/backward blocks
package softmax_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DOT    = 2'd1,
        APPLY  = 2'd2,
        FINISH = 2'd3
    } bwd_state_t;

    localparam int SAT_CALC_W = 64;

    // Clamp a wide signed value into the signed range of a w-bit word (w < 64).
    function automatic logic signed [SAT_CALC_W-1:0] sat_to_width(
        input logic signed [SAT_CALC_W-1:0] v,
        input int                           w
    );
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// rtl/fxp_mul_sat.sv - combinational signed fixed-point multiply, arithmetic shift right by F, saturate
module fxp_mul_sat
    import softmax_pkg::*;
#(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int F         = 8,
    parameter int WIDTH_OUT = 16
) (
    input  logic signed [WIDTH_A-1:0]   a,
    input  logic signed [WIDTH_B-1:0]   b,
    output logic signed [WIDTH_OUT-1:0] p
);

    localparam int PW = WIDTH_A + WIDTH_B;

    logic signed [PW-1:0]         prod;
    logic signed [SAT_CALC_W-1:0] prod_ext;
    logic signed [SAT_CALC_W-1:0] shifted;
    logic signed [SAT_CALC_W-1:0] clamped;

    // Operands are sign-extended to the full product width so the multiply never wraps.
    always_comb begin
        prod     = $signed({{WIDTH_B{a[WIDTH_A-1]}}, a}) * $signed({{WIDTH_A{b[WIDTH_B-1]}}, b});
        prod_ext = {{(SAT_CALC_W-PW){prod[PW-1]}}, prod};
        shifted  = prod_ext >>> F;
        clamped  = sat_to_width(shifted, WIDTH_OUT);
        p        = WIDTH_OUT'(clamped);
    end

endmodule

// File: rtl/softmax_backward.sv
// rtl/softmax_backward.sv - softmax gradient pass dx_i = y_i*(g_i - sum_j g_j*y_j), one term per cycle
module softmax_backward
    import softmax_pkg::*;
#(
    parameter int WIDTH             = 16,
    parameter int DIMENSION         = 10,
    parameter int FIXED_POINT_INDEX = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [DIMENSION-1:0][WIDTH-1:0]   y_data,
    input  logic [DIMENSION-1:0][WIDTH-1:0]   grad_in,
    output logic [DIMENSION-1:0][WIDTH-1:0]   grad_out,
    output logic                              busy,
    output logic                              done
);

    localparam int IW     = $clog2(DIMENSION) + 1;
    localparam int ACC_W  = 2 * WIDTH + $clog2(DIMENSION);
    localparam int DIFF_W = WIDTH + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIMENSION - 1);

    bwd_state_t                        state;
    logic [IW-1:0]                     idx;
    logic signed [ACC_W-1:0]           acc;
    logic signed [WIDTH-1:0]           dot;
    logic [DIMENSION-1:0][WIDTH-1:0]   y_reg;
    logic [DIMENSION-1:0][WIDTH-1:0]   g_reg;

    logic signed [WIDTH-1:0]           y_cur;
    logic signed [WIDTH-1:0]           g_cur;
    logic signed [ACC_W-1:0]           term;
    logic signed [ACC_W-1:0]           acc_next;
    logic signed [SAT_CALC_W-1:0]      acc_ext;
    logic signed [WIDTH-1:0]           dot_sat;
    logic signed [DIFF_W-1:0]          diff;
    logic signed [WIDTH-1:0]           apply_out;

    always_comb begin
        y_cur = '0;
        g_cur = '0;
        for (int k = 0; k < DIMENSION; k++) begin
            if (idx == IW'(k)) begin
                y_cur = y_reg[k];
                g_cur = g_reg[k];
            end
        end
    end

    // DOT term: the accumulator width already holds any product, so no clamping occurs here.
    fxp_mul_sat #(
        .WIDTH_A   (WIDTH),
        .WIDTH_B   (WIDTH),
        .F         (FIXED_POINT_INDEX),
        .WIDTH_OUT (ACC_W)
    ) u_dot_mul (
        .a (y_cur),
        .b (g_cur),
        .p (term)
    );

    always_comb begin
        acc_next = acc + term;
        acc_ext  = {{(SAT_CALC_W-ACC_W){acc_next[ACC_W-1]}}, acc_next};
        dot_sat  = WIDTH'(sat_to_width(acc_ext, WIDTH));
        diff     = {g_cur[WIDTH-1], g_cur} - {dot[WIDTH-1], dot};
    end

    fxp_mul_sat #(
        .WIDTH_A   (WIDTH),
        .WIDTH_B   (DIFF_W),
        .F         (FIXED_POINT_INDEX),
        .WIDTH_OUT (WIDTH)
    ) u_apply_mul (
        .a (y_cur),
        .b (diff),
        .p (apply_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            dot      <= '0;
            y_reg    <= '0;
            g_reg    <= '0;
            grad_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        y_reg <= y_data;
                        g_reg <= grad_in;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= DOT;
                    end
                end
                DOT: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        dot   <= dot_sat;
                        idx   <= '0;
                        state <= APPLY;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                APPLY: begin
                    for (int k = 0; k < DIMENSION; k++) begin
                        if (idx == IW'(k)) begin
                            grad_out[k] <= apply_out;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
